pipeline_control: RTL and testbench
===================================

Name: pipeline_control

Overview:
Central sequencer for the five-stage MIPS pipeline (IF, ID, EX, MEM, WB). It gates every pipeline-register enable and supports free-run and single-step (debug) execution. It detects load-use hazards in ID against EX and inserts bubbles, flushes wrong-path instructions on a taken branch, and drains the pipeline after a HALT. It sits beside the stage modules and drives their enable/flush inputs. It also counts executed clock cycles for the debug unit.

Parameters:
NB, 5, register index width
DRAIN_CYCLES, 3, advancing cycles needed after HALT leaves ID until it retires from WB
LEN_CNT, 32, cycle counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (asserted when 0)
in_run  in  1  start free-run (level or pulse)
in_debug_mode  in  1  1 = single-step mode
in_step  in  1  one-cycle pulse, advance one clock in debug mode
in_id_rs  in  NB  rs of instruction in ID
in_id_rt  in  NB  rt of instruction in ID
in_id_halt  in  1  instruction in ID is HALT
in_ex_mem_read  in  1  instruction in EX is a load
in_ex_rt  in  NB  destination rt of the load in EX
in_branch_taken  in  1  branch resolved taken (from EX/MEM register)
out_enable_pc  out  1  PC load enable
out_enable_if_id  out  1  IF/ID register enable
out_enable_id_ex  out  1  ID/EX register enable
out_enable_ex_mem  out  1  EX/MEM register enable
out_enable_mem_wb  out  1  MEM/WB register enable
out_bubble  out  1  ID/EX loads zeroed execute/memory/writeBack buses
out_flush_if_id  out  1  clear IF/ID on next edge
out_flush_id_ex  out  1  clear ID/EX on next edge
out_flush_ex_mem  out  1  clear EX/MEM on next edge
out_state  out  3  current FSM state encoding
out_halted  out  1  program finished
out_cycle_count  out  LEN_CNT  advancing cycles since reset

Behaviour:
- States:
  - IDLE=000, RUN=001, STEP=010, DRAIN=011, DONE=100.
  - State, drain counter, out_halted and out_cycle_count are registered. Enables, bubble and flushes are combinational from state and inputs.
- Reset (reset=0, async):
  - state=IDLE, drain counter=0, out_halted=0, out_cycle_count=0.
  - All enables, bubble and flushes read 0 while in reset.
- adv = state in {RUN, STEP, DRAIN}. When adv=0, all enables, bubble and flushes are 0.
- IDLE transitions:
  - in_debug_mode=1 and in_step=1 -> STEP.
  - in_debug_mode=0 and in_run=1 -> RUN.
  - in_run is ignored in debug mode. If in_run and in_step are both high, in_debug_mode alone decides.
- STEP: exactly one advancing cycle. The next state is IDLE, or DRAIN if HALT is accepted this cycle.
- RUN: remains RUN until HALT is accepted. Clearing in_debug_mode or in_run has no effect.
- Hazard and control rules, with adv=1 and priority branch > halt > stall:
  - Default: all five enables = 1, bubble = 0, flushes = 0.
  - Branch (in_branch_taken=1):
    - out_flush_if_id = out_flush_id_ex = out_flush_ex_mem = 1.
    - All enables = 1, so PC loads the target.
    - Any stall or halt request is ignored this cycle; the flushed instructions are wrong-path.
  - Halt accept (in_id_halt=1, no branch):
    - out_enable_pc = 0 and out_enable_if_id = 0. Downstream enables = 1.
    - Next state = DRAIN, counter = DRAIN_CYCLES.
  - Load-use stall:
    - Condition: in_ex_mem_read=1, in_ex_rt != 0, and in_ex_rt equals in_id_rs or in_id_rt.
    - out_enable_pc = 0, out_enable_if_id = 0, out_bubble = 1. ID/EX, EX/MEM and MEM/WB are enabled.
    - Exactly one bubble is inserted per load, because the load leaves EX on the next edge.
- DRAIN:
  - PC and IF/ID are disabled. ID/EX is enabled with out_bubble=1. EX/MEM and MEM/WB are enabled.
  - A taken branch in DRAIN does not flush and is ignored; it is older than HALT and already retiring.
  - The counter decrements each cycle. Leaving DRAIN with the counter at 1 -> DONE.
- DONE: all enables 0, out_halted=1. Stays until reset; in_run and in_step are ignored.
- out_cycle_count: +1 on every edge where adv=1, saturating at 2^LEN_CNT-1.
- Reset mid-operation: returns to IDLE immediately, counter cleared, regardless of state.

Test Plan:
1. reset=0 then 1, in_debug_mode=0, in_run=1 -> state 000 then 001; all enables 1; out_cycle_count increments 1,2,3...
2. RUN with in_ex_mem_read=1, in_ex_rt=5, in_id_rs=5 for one cycle -> that cycle: enable_pc=0, enable_if_id=0, bubble=1, other enables 1. Same with in_ex_rt=0 -> no stall.
3. RUN, in_branch_taken=1 together with an active load-use match and in_id_halt=1 -> all three flushes 1, all enables 1, bubble=0, state stays RUN.
4. Debug mode, three in_step pulses spaced 4 cycles apart -> STEP for exactly 3 cycles total; out_cycle_count=3; enables 0 in all IDLE cycles.
5. RUN, in_id_halt=1 at cycle N -> DRAIN for cycles N+1..N+3 (pc/if_id 0, bubble 1); DONE at N+4 with out_halted=1; count stops; in_run toggling has no effect.
6. Assert reset=0 asynchronously mid-DRAIN -> outputs drop to 0 and state reads 000 before the next clk edge; counter is 0 after release.

Source files
------------

// File: rtl/pipeline_control_if.sv
// Control bus between the pipeline sequencer and the five pipeline stages.
// master: sequencer side (takes stage status, drives enables/flushes/status).
// slave : stage/environment side (drives stage status, takes enables/flushes).
// Signals:
//   in_run, in_debug_mode, in_step           run/debug requests
//   in_id_rs, in_id_rt, in_id_halt           ID-stage operands and HALT flag
//   in_ex_mem_read, in_ex_rt                 EX-stage load and its destination
//   in_branch_taken                          resolved taken branch
//   out_enable_*                             pipeline-register load enables
//   out_bubble, out_flush_*                  bubble insert / wrong-path clear
//   out_state, out_halted, out_cycle_count   sequencer status
interface pipeline_control_if #(
  parameter int unsigned NB      = 5,
  parameter int unsigned LEN_CNT = 32
);
  logic               in_run;
  logic               in_debug_mode;
  logic               in_step;
  logic [NB-1:0]      in_id_rs;
  logic [NB-1:0]      in_id_rt;
  logic               in_id_halt;
  logic               in_ex_mem_read;
  logic [NB-1:0]      in_ex_rt;
  logic               in_branch_taken;
  logic               out_enable_pc;
  logic               out_enable_if_id;
  logic               out_enable_id_ex;
  logic               out_enable_ex_mem;
  logic               out_enable_mem_wb;
  logic               out_bubble;
  logic               out_flush_if_id;
  logic               out_flush_id_ex;
  logic               out_flush_ex_mem;
  logic [2:0]         out_state;
  logic               out_halted;
  logic [LEN_CNT-1:0] out_cycle_count;

  modport master (
    input  in_run, in_debug_mode, in_step, in_id_rs, in_id_rt, in_id_halt,
           in_ex_mem_read, in_ex_rt, in_branch_taken,
    output out_enable_pc, out_enable_if_id, out_enable_id_ex, out_enable_ex_mem,
           out_enable_mem_wb, out_bubble, out_flush_if_id, out_flush_id_ex,
           out_flush_ex_mem, out_state, out_halted, out_cycle_count
  );

  modport slave (
    output in_run, in_debug_mode, in_step, in_id_rs, in_id_rt, in_id_halt,
           in_ex_mem_read, in_ex_rt, in_branch_taken,
    input  out_enable_pc, out_enable_if_id, out_enable_id_ex, out_enable_ex_mem,
           out_enable_mem_wb, out_bubble, out_flush_if_id, out_flush_id_ex,
           out_flush_ex_mem, out_state, out_halted, out_cycle_count
  );
endinterface

// File: rtl/pipeline_control.sv
// Central sequencer for the five-stage MIPS pipeline. Gates all pipeline-register
// enables, supports free-run and single-step, stalls on load-use hazards, flushes
// wrong-path instructions on a taken branch and drains the pipeline after HALT.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous reset, active-low
//   bus    pipeline_control_if.master (stage status in, enables/flushes/status out)
module pipeline_control #(
  parameter int unsigned NB           = 5,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned LEN_CNT      = 32
) (
  input logic                clk,
  input logic                reset,
  pipeline_control_if.master bus
);

  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StRun   = 3'b001,
    StStep  = 3'b010,
    StDrain = 3'b011,
    StDone  = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic               halted_q;
  logic [LEN_CNT-1:0] cnt_q;

  logic [NB-1:0] id_rs, id_rt, ex_rt;
  logic          adv, load_use, halt_acc;

  assign id_rs = bus.in_id_rs;
  assign id_rt = bus.in_id_rt;
  assign ex_rt = bus.in_ex_rt;

  assign adv      = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);
  // $zero is never a real dependency, so a load into it cannot cause a stall.
  assign load_use = bus.in_ex_mem_read && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  // A taken branch squashes the HALT in ID, so it is not accepted that cycle.
  assign halt_acc = bus.in_id_halt && !bus.in_branch_taken;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      StIdle: begin
        if (bus.in_debug_mode) begin
          if (bus.in_step) state_d = StStep;
        end else if (bus.in_run) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (halt_acc) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYCLES);
        end
      end
      StStep: begin
        if (halt_acc) begin
          state_d = StDrain;
          drain_d = DrainW'(DRAIN_CYCLES);
        end else begin
          state_d = StIdle;
        end
      end
      StDrain: begin
        drain_d = drain_q - 1'b1;
        if (drain_q <= DrainW'(1)) state_d = StDone;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      drain_q  <= '0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == StDone);
      if (adv && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    bus.out_enable_pc     = 1'b0;
    bus.out_enable_if_id  = 1'b0;
    bus.out_enable_id_ex  = 1'b0;
    bus.out_enable_ex_mem = 1'b0;
    bus.out_enable_mem_wb = 1'b0;
    bus.out_bubble        = 1'b0;
    bus.out_flush_if_id   = 1'b0;
    bus.out_flush_id_ex   = 1'b0;
    bus.out_flush_ex_mem  = 1'b0;
    case (state_q)
      StRun, StStep: begin
        bus.out_enable_pc     = 1'b1;
        bus.out_enable_if_id  = 1'b1;
        bus.out_enable_id_ex  = 1'b1;
        bus.out_enable_ex_mem = 1'b1;
        bus.out_enable_mem_wb = 1'b1;
        if (bus.in_branch_taken) begin
          bus.out_flush_if_id  = 1'b1;
          bus.out_flush_id_ex  = 1'b1;
          bus.out_flush_ex_mem = 1'b1;
        end else if (bus.in_id_halt) begin
          bus.out_enable_pc    = 1'b0;
          bus.out_enable_if_id = 1'b0;
        end else if (load_use) begin
          bus.out_enable_pc    = 1'b0;
          bus.out_enable_if_id = 1'b0;
          bus.out_bubble       = 1'b1;
        end
      end
      StDrain: begin
        // Branches here are older than HALT and already retiring: no flush.
        bus.out_enable_id_ex  = 1'b1;
        bus.out_enable_ex_mem = 1'b1;
        bus.out_enable_mem_wb = 1'b1;
        bus.out_bubble        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.out_state       = state_q;
  assign bus.out_halted      = halted_q;
  assign bus.out_cycle_count = cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed self-checking bench for pipeline_control. Inputs change on the falling
// edge; outputs are checked shortly after, away from the rising edge.
module tb_pipeline_control;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipeline_control_if #(.NB(5), .LEN_CNT(32)) bus ();

  pipeline_control #(
    .NB          (5),
    .DRAIN_CYCLES(3),
    .LEN_CNT     (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {pc, if_id, id_ex, ex_mem, mem_wb}
  function automatic logic [31:0] en_vec();
    return {27'd0, bus.out_enable_pc, bus.out_enable_if_id, bus.out_enable_id_ex,
            bus.out_enable_ex_mem, bus.out_enable_mem_wb};
  endfunction

  // {bubble, flush_if_id, flush_id_ex, flush_ex_mem}
  function automatic logic [31:0] ctl_vec();
    return {28'd0, bus.out_bubble, bus.out_flush_if_id, bus.out_flush_id_ex,
            bus.out_flush_ex_mem};
  endfunction

  task automatic step_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_hazards();
    bus.in_id_rs        = '0;
    bus.in_id_rt        = '0;
    bus.in_id_halt      = 1'b0;
    bus.in_ex_mem_read  = 1'b0;
    bus.in_ex_rt        = '0;
    bus.in_branch_taken = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    bus.in_run        = 1'b1;
    bus.in_debug_mode = 1'b0;
    bus.in_step       = 1'b0;
    clear_hazards();

    // Reset holds everything idle even with in_run high.
    step_neg();
    step_neg();
    check("rst_state", 32'(bus.out_state), 32'd0);
    check("rst_en", en_vec(), 32'h00);
    check("rst_ctl", ctl_vec(), 32'h0);
    check("rst_halted", 32'(bus.out_halted), 32'd0);
    check("rst_cnt", bus.out_cycle_count, 32'd0);
    reset = 1'b1;

    // IDLE -> RUN; in_run dropping afterwards is ignored.
    step_neg();
    check("run_state", 32'(bus.out_state), 32'd1);
    check("run_en", en_vec(), 32'h1F);
    check("run_ctl", ctl_vec(), 32'h0);
    check("run_cnt0", bus.out_cycle_count, 32'd0);
    bus.in_run = 1'b0;
    step_neg();
    check("run_cnt1", bus.out_cycle_count, 32'd1);
    check("run_hold", 32'(bus.out_state), 32'd1);
    step_neg();
    check("run_cnt2", bus.out_cycle_count, 32'd2);

    // Load-use on rs.
    bus.in_ex_mem_read = 1'b1;
    bus.in_ex_rt       = 5'd5;
    bus.in_id_rs       = 5'd5;
    #1;
    check("lu_rs_en", en_vec(), 32'h07);
    check("lu_rs_ctl", ctl_vec(), 32'h8);
    // Load into $zero never stalls.
    bus.in_ex_rt = 5'd0;
    bus.in_id_rs = 5'd0;
    #1;
    check("lu_zero_en", en_vec(), 32'h1F);
    check("lu_zero_ctl", ctl_vec(), 32'h0);
    // Load-use on rt.
    bus.in_ex_rt = 5'd7;
    bus.in_id_rt = 5'd7;
    #1;
    check("lu_rt_en", en_vec(), 32'h07);
    check("lu_rt_ctl", ctl_vec(), 32'h8);
    // Non-matching register: no stall.
    bus.in_id_rt = 5'd6;
    #1;
    check("lu_miss_en", en_vec(), 32'h1F);

    // Branch beats halt and stall together.
    bus.in_id_rt        = 5'd7;
    bus.in_id_halt      = 1'b1;
    bus.in_branch_taken = 1'b1;
    #1;
    check("br_en", en_vec(), 32'h1F);
    check("br_ctl", ctl_vec(), 32'h7);
    step_neg();
    clear_hazards();
    check("br_state", 32'(bus.out_state), 32'd1);
    check("br_cnt", bus.out_cycle_count, 32'd3);

    // HALT accept, then three DRAIN cycles, then DONE.
    bus.in_id_halt = 1'b1;
    #1;
    check("halt_en", en_vec(), 32'h07);
    check("halt_ctl", ctl_vec(), 32'h0);
    step_neg();
    bus.in_id_halt      = 1'b0;
    bus.in_branch_taken = 1'b1;
    #1;
    check("dr1_state", 32'(bus.out_state), 32'd3);
    check("dr1_en", en_vec(), 32'h07);
    check("dr1_ctl", ctl_vec(), 32'h8);
    check("dr1_cnt", bus.out_cycle_count, 32'd4);
    step_neg();
    bus.in_branch_taken = 1'b0;
    check("dr2_state", 32'(bus.out_state), 32'd3);
    check("dr2_cnt", bus.out_cycle_count, 32'd5);
    step_neg();
    check("dr3_state", 32'(bus.out_state), 32'd3);
    check("dr3_halted", 32'(bus.out_halted), 32'd0);
    step_neg();
    check("done_state", 32'(bus.out_state), 32'd4);
    check("done_halted", 32'(bus.out_halted), 32'd1);
    check("done_en", en_vec(), 32'h00);
    check("done_ctl", ctl_vec(), 32'h0);
    check("done_cnt", bus.out_cycle_count, 32'd7);
    bus.in_run  = 1'b1;
    bus.in_step = 1'b1;
    step_neg();
    bus.in_run  = 1'b0;
    step_neg();
    bus.in_step = 1'b0;
    check("done_stay", 32'(bus.out_state), 32'd4);
    check("done_cnt_hold", bus.out_cycle_count, 32'd7);

    // Reset, then debug mode: in_run is ignored, each step pulse gives one STEP.
    reset = 1'b0;
    #1;
    check("rst2_state", 32'(bus.out_state), 32'd0);
    check("rst2_halted", 32'(bus.out_halted), 32'd0);
    step_neg();
    reset             = 1'b1;
    bus.in_debug_mode = 1'b1;
    bus.in_run        = 1'b1;
    step_neg();
    check("dbg_idle", 32'(bus.out_state), 32'd0);
    check("dbg_cnt0", bus.out_cycle_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      bus.in_step = 1'b1;
      step_neg();
      bus.in_step = 1'b0;
      check("stp_state", 32'(bus.out_state), 32'd2);
      check("stp_en", en_vec(), 32'h1F);
      for (int j = 0; j < 3; j++) begin
        step_neg();
        check("stp_idle", 32'(bus.out_state), 32'd0);
        check("stp_idle_en", en_vec(), 32'h00);
      end
      check("stp_cnt", bus.out_cycle_count, 32'(i + 1));
    end

    // Step into a HALT, then assert reset asynchronously mid-DRAIN.
    bus.in_step = 1'b1;
    step_neg();
    bus.in_step    = 1'b0;
    bus.in_id_halt = 1'b1;
    #1;
    check("stp_halt_en", en_vec(), 32'h07);
    step_neg();
    bus.in_id_halt = 1'b0;
    check("stp_drain", 32'(bus.out_state), 32'd3);
    check("stp_drain_cnt", bus.out_cycle_count, 32'd4);
    #1;
    reset = 1'b0;
    #1;
    check("arst_state", 32'(bus.out_state), 32'd0);
    check("arst_en", en_vec(), 32'h00);
    check("arst_ctl", ctl_vec(), 32'h0);
    check("arst_cnt", bus.out_cycle_count, 32'd0);
    step_neg();
    reset             = 1'b1;
    bus.in_debug_mode = 1'b0;
    bus.in_run        = 1'b0;
    step_neg();
    check("post_idle", 32'(bus.out_state), 32'd0);
    check("post_halted", 32'(bus.out_halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
